// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam int unsigned XLEN_DEFAULT      = 32;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

   // Fetch controller states (2-bit encoding).
   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,  // present pc to memory
      ST_WAIT  = 2'd1,  // one request outstanding
      ST_KILL  = 2'd2,  // outstanding request redirected away; drop its response
      ST_HOLD  = 2'd3   // instruction parked while IF/ID is stalled
   } fetch_state_e;

   // Strobes from the controller to the pc/req_pc/hold_instr datapath.
   typedef struct packed {
      logic req_valid;    // drive imem_req_valid
      logic load_req_pc;  // req_pc <= pc (request accepted)
      logic load_target;  // pc <= pctargete (redirect)
      logic load_seq;     // pc <= req_pc + 4 (instruction consumed)
      logic load_hold;    // hold_instr <= imem_rsp_data
      logic sel_rsp;      // present imem_rsp_data as a real instruction
      logic sel_hold;     // present hold_instr as a real instruction
   } fetch_ctrl_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel (fetch side is master).
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) ();

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_stage_ctrl_fsm.sv
// Fetch controller: state register plus next-state and datapath strobe decode.
module fetch_ctrl_fsm
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_pcsrce,
   input  logic        i_stallf,
   input  logic        i_req_ready,
   input  logic        i_rsp_valid,
   output fetch_ctrl_t o_ctrl
);

   fetch_state_e r_state;
   fetch_state_e w_next;

   // Next state and strobes; a redirect outranks a stall in every state.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
      w_next = r_state;
      o_ctrl = '0;
      case (r_state)
         ST_ISSUE: begin
            // A response seen here belongs to a request from before reset; ignore it.
            o_ctrl.req_valid = !i_pcsrce;
            if (i_pcsrce) begin
               o_ctrl.load_target = 1'b1;
            end else if (i_req_ready) begin
               o_ctrl.load_req_pc = 1'b1;
               w_next             = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_rsp_valid) begin
               if (i_pcsrce) begin
                  o_ctrl.load_target = 1'b1;
                  w_next             = ST_ISSUE;
               end else begin
                  o_ctrl.sel_rsp = 1'b1;
                  if (!i_stallf) begin
                     o_ctrl.load_seq = 1'b1;
                     w_next          = ST_ISSUE;
                  end else begin
                     o_ctrl.load_hold = 1'b1;
                     w_next           = ST_HOLD;
                  end
               end
            end else if (i_pcsrce) begin
               o_ctrl.load_target = 1'b1;
               w_next             = ST_KILL;
            end
         end
         ST_KILL: begin
            // Later redirects keep overwriting pc; the last one wins.
            if (i_pcsrce) o_ctrl.load_target = 1'b1;
            if (i_rsp_valid) w_next = ST_ISSUE;
         end
         ST_HOLD: begin
            o_ctrl.sel_hold = 1'b1;
            if (i_pcsrce) begin
               o_ctrl.load_target = 1'b1;
               w_next             = ST_ISSUE;
            end else if (!i_stallf) begin
               o_ctrl.load_seq = 1'b1;
               w_next          = ST_ISSUE;
            end
         end
         default: w_next = ST_ISSUE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) r_state <= ST_ISSUE;
      else        r_state <= w_next;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, talks to imem, feeds IF/ID.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned     XLEN      = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
   parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stallf,
   input  logic              pcsrce,
   input  logic [XLEN-1:0]   pctargete,
   fetch_stage_if.master     imem,
   output logic [31:0]       instrf,
   output logic [XLEN-1:0]   pcf,
   output logic [XLEN-1:0]   pcplus4f,
   output logic              validf,
   output logic              fetch_busyf
);

   logic [XLEN-1:0] r_pc;          // next address to fetch
   logic [XLEN-1:0] r_req_pc;      // address of the outstanding or held request
   logic [31:0]     r_hold_instr;  // instruction parked during a stall
   fetch_ctrl_t     w_ctrl;
   logic [XLEN-1:0] w_req_pc_plus4;

   fetch_ctrl_fsm u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pcsrce    (pcsrce),
      .i_stallf    (stallf),
      .i_req_ready (imem.imem_req_ready),
      .i_rsp_valid (imem.imem_rsp_valid),
      .o_ctrl      (w_ctrl)
   );

   // Address arithmetic wraps modulo 2^XLEN.
   assign w_req_pc_plus4 = r_req_pc + XLEN'(4);

   // PC, request-PC and hold-buffer registers driven by controller strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC;
         r_req_pc     <= RESET_PC;
         r_hold_instr <= NOP_INSTR;
      end else begin
         if (w_ctrl.load_target)   r_pc <= pctargete;
         else if (w_ctrl.load_seq) r_pc <= w_req_pc_plus4;
         if (w_ctrl.load_req_pc)   r_req_pc <= r_pc;
         if (w_ctrl.load_hold)     r_hold_instr <= imem.imem_rsp_data;
      end
   end

   // Instruction mux: live response, held word, or NOP bubble.
   always_comb begin
      instrf = NOP_INSTR;
      if (w_ctrl.sel_rsp)       instrf = imem.imem_rsp_data;
      else if (w_ctrl.sel_hold) instrf = r_hold_instr;
   end

   // No request may leave while reset is asserted.
   assign imem.imem_req_valid = w_ctrl.req_valid & rst_n;
   assign imem.imem_addr      = r_pc;

   assign validf      = w_ctrl.sel_rsp | w_ctrl.sel_hold;
   assign fetch_busyf = ~validf;
   assign pcf         = r_req_pc;
   assign pcplus4f    = w_req_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, scoreboard, directed + random phases.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int unsigned XLEN   = 32;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stallf = 1'b0;
   logic        pcsrce = 1'b0;
   logic [31:0] pctargete = '0;
   logic [31:0] instrf, pcf, pcplus4f;
   logic        validf, fetch_busyf;

   fetch_stage_if #(.XLEN(XLEN)) imem ();

   fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stallf      (stallf),
      .pcsrce      (pcsrce),
      .pctargete   (pctargete),
      .imem        (imem),
      .instrf      (instrf),
      .pcf         (pcf),
      .pcplus4f    (pcplus4f),
      .validf      (validf),
      .fetch_busyf (fetch_busyf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program image: fixed words at 0 and 4, an address hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0)      return 32'h00A0_0093;
      else if (a == 32'h4) return 32'h0010_8113;
      else                 return (a ^ 32'h5A5A_0000) | 32'h0000_0003;
   endfunction

   // ---------------- instruction memory model ----------------
   bit          mem_pending = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   bit          acc_flag = 1'b0;
   logic [31:0] acc_addr = '0;
   bit          lat_rand = 1'b0;
   int          lat_fixed = 1;

   initial begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = '0;
      imem.imem_req_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         imem.imem_rsp_valid = 1'b0;
         if (acc_flag) begin
            mem_pending = 1'b1;
            mem_addr    = acc_addr;
            mem_cnt     = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
            acc_flag    = 1'b0;
         end
         if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               imem.imem_rsp_valid = 1'b1;
               imem.imem_rsp_data  = mem_word(mem_addr);
               mem_pending         = 1'b0;
            end
         end
      end
   end

   // ---------------- reference model + scoreboard monitor ----------------
   // Model: each accepted request yields exactly one instruction unless a redirect
   // intervenes; the next request address is last accepted + 4, or the latest target.
   logic [31:0] q_pc[$];
   logic [31:0] q_instr[$];
   logic [31:0] exp_next = RST_PC;
   int          n_consumed = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
         check("rst_validf", 32'(validf), 32'd0);
         check("rst_instrf", instrf, NOP);
         check("rst_pcf", pcf, RST_PC);
         check("rst_pcplus4f", pcplus4f, RST_PC + 32'd4);
         q_pc.delete();
         q_instr.delete();
         exp_next = RST_PC;
      end else begin
         check("busy_vs_valid", 32'(fetch_busyf), 32'(!validf));
         if (validf) begin
            check("sb_depth", 32'(q_pc.size()), 32'd1);
            if (q_pc.size() > 0) begin
               check("instrf", instrf, q_instr[0]);
               check("pcf", pcf, q_pc[0]);
               check("pcplus4f", pcplus4f, q_pc[0] + 32'd4);
            end
         end else begin
            check("bubble_instrf", instrf, NOP);
         end
         if (imem.imem_req_valid && imem.imem_req_ready) begin
            check("req_addr", imem.imem_addr, exp_next);
            check("one_outstanding", 32'(mem_pending), 32'd0);
            q_pc.push_back(imem.imem_addr);
            q_instr.push_back(mem_word(imem.imem_addr));
            exp_next = imem.imem_addr + 32'd4;
            acc_addr = imem.imem_addr;
            acc_flag = 1'b1;
         end
         if (pcsrce) begin
            check("no_req_on_redirect", 32'(imem.imem_req_valid), 32'd0);
            q_pc.delete();
            q_instr.delete();
            exp_next = pctargete;
         end else if (validf && !stallf) begin
            if (q_pc.size() > 0) begin
               void'(q_pc.pop_front());
               void'(q_instr.pop_front());
            end
            n_consumed++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem.imem_req_ready = 1'b0;
      pcsrce = 1'b0;
      stallf = 1'b0;
      lat_rand = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 10 && mem_pending; k++) tick();
      check("mem_idle_before_release", 32'(mem_pending), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      int  c0;
      bit  found;
      logic [31:0] r;

      // 1: back-to-back fetch, 1-cycle memory: one instruction every 2 cycles.
      lat_fixed = 1;
      do_reset();
      imem.imem_req_ready = 1'b1;
      c0 = n_consumed;
      repeat (10) tick();
      check("t1_throughput", 32'(n_consumed - c0), 32'd5);

      // 2: stall on arrival for 3 cycles, then release.
      do_reset();
      imem.imem_req_ready = 1'b1;
      stallf = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k == 3) stallf = 1'b0;
         #3;
         check("t2_validf", 32'(validf), 32'd1);
         check("t2_instrf", instrf, 32'h00A0_0093);
         check("t2_no_req", 32'(imem.imem_req_valid), 32'd0);
         tick();
      end
      #3;
      check("t2_next_req", 32'(imem.imem_req_valid), 32'd1);
      check("t2_next_addr", imem.imem_addr, 32'h4);

      // 3: redirect while waiting on addr 0x8 with a 3-cycle memory.
      lat_fixed = 3;
      do_reset();
      imem.imem_req_ready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
         #3;
         if (imem.imem_req_valid && imem.imem_addr == 32'h8) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("t3_reached_addr8", 32'(found), 32'd1);
      tick();
      pcsrce = 1'b1;
      pctargete = 32'h100;
      #3;
      check("t3_validf_redirect", 32'(validf), 32'd0);
      tick();
      pcsrce = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #3;
         if (imem.imem_req_valid) begin
            found = 1'b1;
            break;
         end
         check("t3_late_rsp_dropped", 32'(validf), 32'd0);
         tick();
      end
      check("t3_req_seen", 32'(found), 32'd1);
      check("t3_target_addr", imem.imem_addr, 32'h100);

      // 4: redirect coinciding with response, then redirect+stall in HOLD.
      lat_fixed = 1;
      do_reset();
      imem.imem_req_ready = 1'b1;
      tick();
      pcsrce = 1'b1;
      pctargete = 32'h200;
      #3;
      check("t4_rsp_dropped", 32'(validf), 32'd0);
      tick();
      pcsrce = 1'b0;
      #3;
      check("t4_req_target", imem.imem_addr, 32'h200);
      check("t4_req_valid", 32'(imem.imem_req_valid), 32'd1);
      tick();
      stallf = 1'b1;
      #3;
      check("t4_stalled_valid", 32'(validf), 32'd1);
      check("t4_stalled_instr", instrf, mem_word(32'h200));
      tick();
      pcsrce = 1'b1;
      pctargete = 32'h300;
      #3;
      check("t4_hold_valid", 32'(validf), 32'd1);
      check("t4_hold_no_req", 32'(imem.imem_req_valid), 32'd0);
      tick();
      pcsrce = 1'b0;
      stallf = 1'b0;
      #3;
      check("t4_redirect_wins", imem.imem_addr, 32'h300);
      check("t4_redirect_req", 32'(imem.imem_req_valid), 32'd1);
      check("t4_held_dropped", 32'(validf), 32'd0);

      // 5/6: reset mid-WAIT, stale response ignored, ready low 5 cycles, address wrap.
      lat_fixed = 3;
      do_reset();
      imem.imem_req_ready = 1'b1;
      tick();
      rst_n = 1'b0;
      imem.imem_req_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #3;
         check("t5_no_valid", 32'(validf), 32'd0);
         check("t6_req_held", 32'(imem.imem_req_valid), 32'd1);
         check("t6_addr_stable", imem.imem_addr, RST_PC);
         tick();
      end
      check("t5_stale_drained", 32'(mem_pending), 32'd0);
      lat_fixed = 1;
      pcsrce = 1'b1;
      pctargete = 32'hFFFF_FFFC;
      #3;
      check("t6_redirect_no_req", 32'(imem.imem_req_valid), 32'd0);
      tick();
      pcsrce = 1'b0;
      imem.imem_req_ready = 1'b1;
      #3;
      check("t6_wrap_req", imem.imem_addr, 32'hFFFF_FFFC);
      tick();
      #3;
      check("t6_wrap_valid", 32'(validf), 32'd1);
      check("t6_wrap_pcplus4", pcplus4f, 32'h0);
      tick();
      #3;
      check("t6_wrap_next", imem.imem_addr, 32'h0);

      // Random phase against the scoreboard.
      lat_rand = 1'b1;
      c0 = n_consumed;
      for (int k = 0; k < 3000; k++) begin
         tick();
         imem.imem_req_ready = ($urandom_range(0, 3) != 0);
         stallf = ($urandom_range(0, 3) == 0);
         pcsrce = ($urandom_range(0, 15) == 0);
         r = $urandom();
         pctargete = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (r & ~32'h3);
      end
      tick();
      pcsrce = 1'b0;
      stallf = 1'b0;
      imem.imem_req_ready = 1'b1;
      repeat (20) tick();
      check("rand_progress", 32'(n_consumed > c0 + 100), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RISC-V core, directly upstream of the IF/ID pipeline register. It owns the fetch PC and the next-PC selection, and issues one word request at a time to a variable-latency instruction memory over a valid/ready handshake. It handles redirects from EX, including killing in-flight requests, and presents instrf/pcf/pcplus4f to IF/ID. When no instruction is ready, it presents a NOP bubble.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stallf  in  1  hazard unit: hold current fetch output (IF/ID enable low)
pcsrce  in  1  redirect taken (branch/jump resolved in EX)
pctargete  in  XLEN  redirect target address
imem_req_valid  out  1  request address valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  word address of request
imem_rsp_valid  in  1  response data valid (1 cycle pulse)
imem_rsp_data  in  32  fetched instruction
instrf  out  32  instruction to IF/ID
pcf  out  XLEN  PC of instrf
pcplus4f  out  XLEN  pcf + 4
validf  out  1  instrf is a real instruction
fetch_busyf  out  1  ~validf; hazard unit stalls/clears IF/ID on it

Behaviour:
- Registers: pc (next address to fetch), req_pc (address of outstanding/held request), hold_instr (32-bit buffer), state.
- States: ISSUE, WAIT, KILL, HOLD.
- Reset (async, rst_n=0): pc=RESET_PC, req_pc=RESET_PC, hold_instr=NOP_INSTR, state=ISSUE.
- Outputs while in reset: imem_req_valid=0, validf=0, instrf=NOP_INSTR, pcf=RESET_PC, pcplus4f=RESET_PC+4.
- Output defaults whenever there is no real instruction: instrf=NOP_INSTR, validf=0, pcf=req_pc, pcplus4f=req_pc+4.
- All adds are modulo 2^XLEN; wrap from 32'hFFFF_FFFC goes to 0 silently.
- imem_addr=pc. imem_req_valid=(state==ISSUE) && !pcsrce.
- ISSUE:
  - pcsrce=1: pc<=pctargete, stay in ISSUE, no request is issued.
  - Else, on req_valid&&req_ready: req_pc<=pc, go to WAIT.
  - imem_rsp_valid in ISSUE is ignored (covers reset mid-flight).
- WAIT:
  - rsp_valid && pcsrce: discard the response, pc<=pctargete, go to ISSUE.
  - rsp_valid && !pcsrce && !stallf: validf=1, instrf=rsp_data (combinational pass-through), pc<=req_pc+4, go to ISSUE.
  - rsp_valid && !pcsrce && stallf: validf=1, instrf=rsp_data, hold_instr<=rsp_data, go to HOLD.
  - !rsp_valid && pcsrce: pc<=pctargete, go to KILL.
- KILL: wait for rsp_valid, discard it, go to ISSUE. Outputs are the bubble. Any pcsrce here updates pc<=pctargete (last redirect wins).
- HOLD: validf=1, instrf=hold_instr.
  - pcsrce: pc<=pctargete, go to ISSUE; the held instruction is dropped.
  - Else !stallf: pc<=req_pc+4, go to ISSUE.
  - Else stay in HOLD.
- Redirect has priority over stall in every state.
- At most one outstanding request.
- Best-case throughput is 1 instruction per 2 cycles (1-cycle memory); latency from acceptance is memory latency + 0 cycles.
- Illegal state encodings recover to ISSUE.

Decomposition:
- Shared core constants file: NOP_INSTR, RESET_PC default, fetch state encodings (2-bit).
- One natural sub-module, fetch_ctrl_fsm: state register and next-state logic, producing load/select strobes for the pc/req_pc/hold_instr datapath in fetch_stage.

Test Plan:
1. Reset, memory ready with 1-cycle latency returning 0x00A00093 then 0x00108113 -> first request addr 0x0; validf pulses with pcf=0x0 then pcf=0x4; pcplus4f=0x4/0x8; bubbles (instrf=0x13, validf=0) in between.
2. Response 0x00A00093 arrives with stallf=1 for 3 cycles -> instrf holds 0x00A00093, validf=1 for all 4 cycles, no new request until stallf drops, next addr 0x4.
3. pcsrce=1, pctargete=0x100 while WAIT on addr 0x8 with a 3-cycle memory -> late response discarded (validf stays 0), next request addr 0x100.
4. pcsrce and rsp_valid in the same cycle -> response dropped, next imem_addr=target; pcsrce and stallf together in HOLD -> redirect wins.
5. rst_n pulsed low mid-WAIT, then a stale rsp_valid -> ignored; fetch restarts at RESET_PC with validf=0.
6. req_ready held low 5 cycles -> imem_req_valid stays 1 with stable imem_addr, outputs stay bubble; pc=0xFFFF_FFFC fetch -> next addr 0x0.
